// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed multiply/divide producing the Hi/Lo
// registers of the multicycle MIPS datapath. Multiply uses radix-2 Booth
// and divide uses restoring division on magnitudes. Each takes WIDTH
// iterations plus one FINISH edge that writes hi/lo and pulses done.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  // Booth register {A, Q, Q-1}. A carries one guard bit so that
  // subtracting the most negative multiplicand cannot overflow.
  logic [2*WIDTH+1:0] prod;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic               op_q;
  logic               neg_q;
  logic               neg_r;

  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   mcand_ext;
  logic [WIDTH:0]   booth_a;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // Next-iteration datapath values: Booth add/sub, restoring trial subtract,
  // and operand magnitudes for the divide setup.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    acc       = prod[2*WIDTH+1:WIDTH+1];
    mcand_ext = {mcand[WIDTH-1], mcand};
    booth_a   = acc;
    case (prod[1:0])
      2'b01:   booth_a = acc + mcand_ext;
      2'b10:   booth_a = acc - mcand_ext;
      default: booth_a = acc;
    endcase
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    a_mag   = a[WIDTH-1] ? -a : a;
    b_mag   = b[WIDTH-1] ? -b : b;
  end

  // Controller and datapath registers: one iteration per edge, results and
  // done written together on the FINISH edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: state uses non-blocking assignments so every register samples
      // pre-edge values regardless of statement order.
      state    <= IDLE;
      cnt      <= '0;
      prod     <= '0;
      mcand    <= '0;
      divisor  <= '0;
      rem      <= '0;
      quo      <= '0;
      op_q     <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (!op) begin
              state <= MULT;
              cnt   <= '0;
              op_q  <= 1'b0;
              prod  <= {{(WIDTH+1){1'b0}}, a, 1'b0};
              mcand <= b;
            end else if (b != '0) begin
              state   <= DIV;
              cnt     <= '0;
              op_q    <= 1'b1;
              rem     <= '0;
              quo     <= a_mag;
              divisor <= b_mag;
              neg_q   <= a[WIDTH-1] ^ b[WIDTH-1];
              neg_r   <= a[WIDTH-1];
            end else begin
              done     <= 1'b1;
              div_zero <= 1'b1;
            end
          end
        end
        MULT: begin
          busy <= 1'b1;
          cnt  <= cnt + 1'b1;
          prod <= {booth_a[WIDTH], booth_a, prod[WIDTH:1]};
          if (cnt == CNT_W'(WIDTH-1)) state <= FINISH;
        end
        DIV: begin
          busy <= 1'b1;
          cnt  <= cnt + 1'b1;
          if (trial[WIDTH]) begin
            rem <= shifted[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end else begin
            rem <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end
          if (cnt == CNT_W'(WIDTH-1)) state <= FINISH;
        end
        FINISH: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
          if (op_q) begin
            lo <= neg_q ? -quo : quo;
            hi <= neg_r ? -rem : rem;
          end else begin
            hi <= prod[2*WIDTH:WIDTH+1];
            lo <= prod[WIDTH:1];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: directed corner cases plus random operations
// checked against a plain-arithmetic signed multiply/divide model.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;
  logic         div_zero;

  int errors = 0;
  int checks = 0;

  mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  // Reference: {hi, lo} from signed 64-bit arithmetic. SV integer division
  // truncates toward zero and % takes the sign of the dividend.
  function automatic logic [63:0] model(input logic op_i, input logic [W-1:0] a_i,
                                        input logic [W-1:0] b_i);
    longint pa, pb, p, q, r;
    pa = longint'($signed(a_i));
    pb = longint'($signed(b_i));
    if (!op_i) begin
      p = pa * pb;
      return p[63:0];
    end
    q = pa / pb;
    r = pa % pb;
    return {r[31:0], q[31:0]};
  endfunction

  // Issue one operation and watch it to completion. Caller must be away
  // from the clock edge. Optionally pulses a stray div start (b = 0) at
  // edge 'inject'. Reports done edge, busy cycles, busy/div_zero at done,
  // and whether hi/lo held their old values until done.
  task automatic run_op(input logic op_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                        input int inject, output int done_edge, output int busy_cycles,
                        output logic busy_at_done, output logic dz_at_done,
                        output logic hold_ok);
    logic [W-1:0] prev_hi, prev_lo;
    prev_hi      = hi;
    prev_lo      = lo;
    done_edge    = -1;
    busy_cycles  = 0;
    busy_at_done = 1'bx;
    dz_at_done   = 1'bx;
    hold_ok      = 1'b1;
    start = 1'b1;
    op    = op_i;
    a     = a_i;
    b     = b_i;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    if (done || hi !== prev_hi || lo !== prev_lo) hold_ok = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (e == inject + 1) start = 1'b0;
      if (done) begin
        done_edge    = e;
        busy_at_done = busy;
        dz_at_done   = div_zero;
        break;
      end
      if (busy) busy_cycles++;
      if (hi !== prev_hi || lo !== prev_lo) hold_ok = 1'b0;
      if (e == inject) begin
        start = 1'b1;
        op    = 1'b1;
        a     = $urandom;
        b     = '0;
      end
    end
    start = 1'b0;
  endtask

  // Full check of one completed operation against the model.
  task automatic test_op(input string name, input logic op_i, input logic [W-1:0] a_i,
                         input logic [W-1:0] b_i, input int inject);
    int           de, bc;
    logic         bd, dz, hold;
    logic [63:0]  exp_v;
    exp_v = model(op_i, a_i, b_i);
    run_op(op_i, a_i, b_i, inject, de, bc, bd, dz, hold);
    checks++;
    if (de !== W + 1) begin
      errors++;
      $display("FAIL %s done_edge: got %0d expected %0d", name, de, W + 1);
    end
    checks++;
    if (bc !== W) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, bc, W);
    end
    checks++;
    if (bd !== 1'b0 || dz !== 1'b0) begin
      errors++;
      $display("FAIL %s busy/div_zero at done: got %b/%b expected 0/0", name, bd, dz);
    end
    checks++;
    if (!hold) begin
      errors++;
      $display("FAIL %s hi/lo hold: changed before done", name);
    end
    checks++;
    if (hi !== exp_v[63:32] || lo !== exp_v[31:0]) begin
      errors++;
      $display("FAIL %s result: got hi=%h lo=%h expected hi=%h lo=%h",
               name, hi, lo, exp_v[63:32], exp_v[31:0]);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset: got hi=%h lo=%h busy=%b done=%b dz=%b expected all 0",
               hi, lo, busy, done, div_zero);
    end
  endtask

  task automatic test_mult_directed();
    logic [63:0] v;
    v = model(1'b0, 32'd7, 32'hFFFF_FFFD);
    checks++;
    if (v !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      errors++;
      $display("FAIL model_mult_7x-3: got %h expected FFFFFFFFFFFFFFEB", v);
    end
    test_op("mult_7x-3", 1'b0, 32'd7, 32'hFFFF_FFFD, -10);
    test_op("mult_min_x_min", 1'b0, 32'h8000_0000, 32'h8000_0000, -10);
    test_op("mult_-1x-1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -10);
  endtask

  task automatic test_div_directed();
    test_op("div_-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, -10);
    test_op("div_7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, -10);
    test_op("div_min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -10);
  endtask

  task automatic test_random();
    logic         r_op;
    logic [W-1:0] r_a, r_b;
    for (int i = 0; i < 16; i++) begin
      r_op = i[0];
      r_a  = $urandom;
      r_b  = $urandom;
      if (i[1]) r_b = {{(W-8){r_b[7]}}, r_b[7:0]};
      if (r_op && r_b == '0) r_b = 32'd3;
      test_op($sformatf("random_%0d", i), r_op, r_a, r_b, -10);
    end
  endtask

  task automatic test_div_zero();
    // 0x451 / 0x20 = 0x22 remainder 0x11 preloads hi/lo.
    test_op("preload_div", 1'b1, 32'h451, 32'h20, -10);
    @(negedge clk);
    start = 1'b1;
    op    = 1'b1;
    a     = 32'd5;
    b     = '0;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || div_zero !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL div_zero_pulse: got done=%b dz=%b busy=%b expected 1/1/0",
               done, div_zero, busy);
    end
    checks++;
    if (hi !== 32'h11 || lo !== 32'h22) begin
      errors++;
      $display("FAIL div_zero_hold: got hi=%h lo=%h expected hi=00000011 lo=00000022", hi, lo);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || div_zero !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL div_zero_one_cycle: got done=%b dz=%b busy=%b expected 0/0/0",
               done, div_zero, busy);
    end
  endtask

  task automatic test_ignore_start();
    test_op("mult_with_stray_start", 1'b0, 32'h1234_5678, 32'hFEDC_BA98, 5);
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stray_start_after: got done=%b busy=%b expected 0/0", done, busy);
    end
  endtask

  task automatic test_back_to_back();
    // Second start is driven right after done, i.e. on the next edge.
    test_op("b2b_first", 1'b1, 32'h8765_4321, 32'h0000_1234, -10);
    test_op("b2b_second", 1'b0, 32'hDEAD_BEEF, 32'h0000_0101, -10);
  endtask

  task automatic test_reset_mid();
    int dones;
    test_op("pre_reset_mult", 1'b0, 32'h0001_0003, 32'h0002_0005, -10);
    @(negedge clk);
    start = 1'b1;
    op    = 1'b1;
    a     = 32'd1000;
    b     = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: got hi=%h lo=%h busy=%b done=%b expected 0/0/0/0",
               hi, lo, busy, done);
    end
    @(negedge clk);
    rst   = 1'b1;
    dones = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_done: got %0d done/busy cycles expected 0", dones);
    end
    test_op("after_reset_div", 1'b1, 32'hFFFF_FF00, 32'd9, -10);
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_mult_directed();
    test_div_directed();
    test_random();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
